// File: rtl/adder_tree_arbiter.sv
// adder_tree_arbiter: round-robin arbiter feeding a shared pipelined adder tree, with tag tracking of results.
module adder_tree_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int INPUTS_NUM = 4096,
  parameter int IDATA_WIDTH = 1,
  localparam int STAGES_NUM = $clog2(INPUTS_NUM),
  localparam int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM,
  localparam int LAT = STAGES_NUM + 2,
  localparam int ID_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int CNT_W = $clog2(LAT + 1)
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic [REQ_NUM-1:0] req_valid,
  output logic [REQ_NUM-1:0] req_ready,
  input  logic [REQ_NUM-1:0][INPUTS_NUM-1:0][IDATA_WIDTH-1:0] req_data,
  output logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] tree_idata,
  input  logic [ODATA_WIDTH-1:0] tree_odata,
  output logic res_valid,
  output logic [ID_W-1:0] res_id,
  output logic [ODATA_WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] inflight,
  output logic idle
);
  logic [ID_W-1:0] ptr, win, cand;
  logic hit, hs;
  logic [LAT-2:0] tag_v;
  logic [ID_W-1:0] tag_id [LAT-1];
  always_comb begin
    win = '0;
    hit = 1'b0;
    cand = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = ID_W'((int'(ptr) + k) % REQ_NUM);
      if (!hit && req_valid[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end
  assign hs = nrst && en && hit;
  assign req_ready = hs ? (REQ_NUM'(1) << win) : '0;
  assign idle = (inflight == '0) && !hs;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr <= '0;
      tag_v <= '0;
      inflight <= '0;
      tree_idata <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_data <= '0;
    end else begin
      if (hs) ptr <= (win == ID_W'(REQ_NUM - 1)) ? '0 : win + 1'b1;
      tree_idata <= hs ? req_data[win] : '0;
      tag_v[0] <= hs;
      for (int i = 1; i < LAT - 1; i++) tag_v[i] <= tag_v[i-1];
      // the tag reaching the last stage lines up with the tree sum for the same operand
      res_valid <= tag_v[LAT-2];
      if (tag_v[LAT-2]) begin
        res_id <= tag_id[LAT-2];
        res_data <= tree_odata;
      end
      inflight <= inflight + CNT_W'(hs) - CNT_W'(res_valid);
    end
  end
  always_ff @(posedge clk) begin
    tag_id[0] <= win;
    for (int i = 1; i < LAT - 1; i++) tag_id[i] <= tag_id[i-1];
  end
endmodule

// File: doc/adder_tree_arbiter.md
ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing one pipelined adder tree.
REQ-002 Parameter INPUTS_NUM, default 4096: adder tree input count, not required to be a power of two.
REQ-003 Parameter IDATA_WIDTH, default 1: width of each tree input.
REQ-004 Derived STAGES_NUM = $clog2(INPUTS_NUM); ODATA_WIDTH = IDATA_WIDTH+STAGES_NUM; LAT = STAGES_NUM+2; ID_W = max(1,$clog2(REQ_NUM)).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 nrst  input  1  synchronous, active-low reset.
REQ-007 en  input  1  grant enable; low blocks new grants, in-flight work drains.
REQ-008 req_valid  input  REQ_NUM  per-requester operand valid.
REQ-009 req_ready  output  REQ_NUM  per-requester accept, at most one bit high.
REQ-010 req_data  input  REQ_NUM x INPUTS_NUM x IDATA_WIDTH  per-requester operand vectors.
REQ-011 tree_idata  output  INPUTS_NUM x IDATA_WIDTH  registered operand to the external adder tree.
REQ-012 tree_odata  input  ODATA_WIDTH  sum from the external adder tree, valid STAGES_NUM cycles after tree_idata.
REQ-013 res_valid  output  1  result strobe, one cycle per accepted operand.
REQ-014 res_id  output  ID_W  requester index owning the result.
REQ-015 res_data  output  ODATA_WIDTH  registered sum.
REQ-016 inflight  output  $clog2(LAT+1)  count of accepted operands not yet returned.
REQ-017 idle  output  1  high when inflight==0 and no handshake this cycle.

Function
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr, first i (mod REQ_NUM) with req_valid[i] wins.
REQ-019 req_ready SHALL be combinational: one-hot of the winner when en=1 and any req_valid, else all zero; req_ready SHALL NOT depend on res path (tree cannot stall).
REQ-020 Handshake on req_valid[i]&req_ready[i]; at most one handshake per cycle; throughput one operand per cycle.
REQ-021 On handshake, ptr SHALL become (winner+1) mod REQ_NUM next cycle; without handshake ptr SHALL hold.
REQ-022 tree_idata SHALL register req_data[winner] on handshake and register all-zero otherwise.
REQ-023 A tag pipeline (valid bit + ID_W id) of depth LAT SHALL track each operand; no backpressure, no drop.
REQ-024 Handshake at cycle T SHALL produce res_valid=1, res_id=winner, res_data=tree_odata sampled at T+1+STAGES_NUM, all registered, visible at cycle T+LAT.
REQ-025 Results SHALL return in acceptance order; res_data and res_id SHALL hold last value when res_valid=0.
REQ-026 inflight SHALL increment on handshake, decrement on res_valid, hold on both or neither; SHALL never exceed LAT.
REQ-027 en falling SHALL not cancel operands already accepted; en rising SHALL allow a grant same cycle.
REQ-028 Sum width: ODATA_WIDTH bits, no saturation, no overflow possible by construction.

Reset
REQ-029 nrst=0 at a rising edge SHALL clear ptr to 0, all tag valids, inflight, tree_idata, res_valid, res_id, res_data to 0.
REQ-030 While nrst=0, req_ready SHALL be all zero and idle SHALL be 1 after the first reset edge.
REQ-031 Reset mid-operation SHALL discard all in-flight operands; no res_valid for them after reset release; external tree reset is driven from the same reset domain.

Verification (REQ_NUM=4, INPUTS_NUM=8, IDATA_WIDTH=4: STAGES_NUM=3, LAT=5, ODATA_WIDTH=7)
REQ-032 Single op: req_valid=4'b0100, all inputs 4'hF, handshake cycle 10 -> res_valid only at cycle 15, res_id=2, res_data=120, inflight 1 during cycles 11-15 transitions back to 0.
REQ-033 Saturating load: all req_valid held high from reset release -> grants 0,1,2,3,0,... every cycle; results back-to-back, same order, inflight steady at 5.
REQ-034 Fairness: req_valid=4'b1010, ptr=0 -> grant 1, then 3, then 1; requester 1 never granted twice in a row while 3 waits.
REQ-035 Drain: 3 ops accepted then en=0 with requests pending -> req_ready=0, three results emitted, idle=1 once inflight=0.
REQ-036 Mixed sums: requester 0 inputs 1..8, requester 3 inputs all 0 back-to-back -> res_data 36 (id 0) then 0 (id 3) on consecutive cycles.
REQ-037 Reset mid-flight: nrst=0 one cycle with inflight=3 -> no res_valid for those ops, ptr=0, first post-reset grant to lowest valid index.
